// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Shares the single combinational imem read port between the fetch path
//   (requester 0) and the loader/debug read path (requester 1). Grants are
//   combinational and issued every cycle. Read data is registered, so a grant
//   in cycle T gives rdata/validX in cycle T+1.
//
// Parameters
//   n          data width (imem word width)
//   r          word address width (2**r imem slots)
//   BURST_MAX  max consecutive grants to one requester while the other waits
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   req0/addr0     fetch read request / word address
//   gnt0           fetch granted this cycle (combinational)
//   valid0         rdata holds a fetch result (registered)
//   req1/addr1     loader/debug read request / word address
//   gnt1           loader/debug granted this cycle (combinational)
//   valid1         rdata holds a loader/debug result (registered)
//   rdata          registered read data, shared by both requesters
//   imem_addr      address driven to the imem
//   imem_readdata  combinational read data from the imem
//
// Build option
//   IMEM_ARB_FIXED_PRI_EN  when defined, requester 0 always wins contention;
//                          the owner/run counter are dropped and BURST_MAX is
//                          ignored. Undefined: bounded-run round-robin.

module imem_arbiter #(
  parameter int n         = 32,
  parameter int r         = 6,
  parameter int BURST_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic [r-1:0] addr0,
  output logic         gnt0,
  output logic         valid0,
  input  logic         req1,
  input  logic [r-1:0] addr1,
  output logic         gnt1,
  output logic         valid1,
  output logic [n-1:0] rdata,
  output logic [r-1:0] imem_addr,
  input  logic [n-1:0] imem_readdata
);

  logic w_gnt0;
  logic w_gnt1;

`ifdef IMEM_ARB_FIXED_PRI_EN

  always_comb begin
    w_gnt0 = req0;
    w_gnt1 = req1 & ~req0;
  end

`else

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // r_owner: last requester granted; r_cnt: length of its current run.
  logic          r_owner;
  logic [CW-1:0] r_cnt;
  logic          w_owner_nxt;
  logic [CW-1:0] w_cnt_nxt;

  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    if (req0 && req1) begin
      if (r_cnt == CNT_MAX) begin
        // Run exhausted: hand over to the waiting side.
        w_gnt0      = r_owner;
        w_gnt1      = ~r_owner;
        w_owner_nxt = ~r_owner;
        w_cnt_nxt   = CNT_ONE;
      end else begin
        w_gnt0    = ~r_owner;
        w_gnt1    = r_owner;
        w_cnt_nxt = r_cnt + CNT_ONE;
      end
    end else if (req0 || req1) begin
      w_gnt0 = req0;
      w_gnt1 = req1;
      if (r_owner == req1) begin
        // Uncontended run by the owner: count saturates so a later
        // contention hands over immediately.
        if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end else begin
        w_owner_nxt = req1;
        w_cnt_nxt   = CNT_ONE;
      end
    end else begin
      w_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`endif

  // Grants are forced low while reset is asserted, independent of clk.
  assign gnt0 = w_gnt0 & rst_n;
  assign gnt1 = w_gnt1 & rst_n;

  assign imem_addr = gnt1 ? addr1 : addr0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
    end else begin
      if (gnt0 || gnt1) begin
        rdata <= imem_readdata;
      end
      valid0 <= gnt0;
      valid1 <= gnt1;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // DUT A: BURST_MAX = 4
  logic        req0, req1, gnt0, gnt1, valid0, valid1;
  logic [5:0]  addr0, addr1, imem_addr;
  logic [31:0] rdata, imem_readdata;
  // DUT B: BURST_MAX = 1
  logic        req0_b, req1_b, gnt0_b, gnt1_b, valid0_b, valid1_b;
  logic [5:0]  addr0_b, addr1_b, imem_addr_b;
  logic [31:0] rdata_b, imem_readdata_b;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] last;

  function automatic logic [31:0] mem(input logic [5:0] a);
    return 32'hA500_0000 ^ ({26'd0, a} * 32'h0001_0203);
  endfunction

  assign imem_readdata   = mem(imem_addr);
  assign imem_readdata_b = mem(imem_addr_b);

  imem_arbiter #(.n(32), .r(6), .BURST_MAX(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .valid0(valid0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .valid1(valid1),
    .rdata(rdata), .imem_addr(imem_addr), .imem_readdata(imem_readdata)
  );

  imem_arbiter #(.n(32), .r(6), .BURST_MAX(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0(req0_b), .addr0(addr0_b), .gnt0(gnt0_b), .valid0(valid0_b),
    .req1(req1_b), .addr1(addr1_b), .gnt1(gnt1_b), .valid1(valid1_b),
    .rdata(rdata_b), .imem_addr(imem_addr_b), .imem_readdata(imem_readdata_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle on DUT A: eg = expected grantee (0/1) or -1 for none.
  task automatic step(input logic q0, input logic q1, input int eg);
    req0 = q0;
    req1 = q1;
    #1;
    chk("gnt0", {31'd0, gnt0}, {31'd0, eg == 0});
    chk("gnt1", {31'd0, gnt1}, {31'd0, eg == 1});
    chk("imem_addr", {26'd0, imem_addr}, {26'd0, (eg == 1) ? addr1 : addr0});
    if (eg >= 0) last = mem((eg == 1) ? addr1 : addr0);
    @(posedge clk);
    #1;
    chk("valid0", {31'd0, valid0}, {31'd0, eg == 0});
    chk("valid1", {31'd0, valid1}, {31'd0, eg == 1});
    chk("rdata", rdata, last);
  endtask

  int seq_c[10];
  int r0_s[7];
  int r1_s[7];
  int seq_s[7];
  int eg_b;

  initial begin
`ifdef IMEM_ARB_FIXED_PRI_EN
    seq_c = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    seq_s = '{0, 0, 1, 0, 0, 0, 0};
`else
    seq_c = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    seq_s = '{0, 0, 1, 1, 1, 1, 0};
`endif
    r0_s = '{1, 1, 0, 1, 1, 1, 1};
    r1_s = '{0, 0, 1, 1, 1, 1, 1};

    // Reset held with both requesting
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; addr0 = 6'h02; addr1 = 6'h09;
    req0_b = 1'b1; req1_b = 1'b1; addr0_b = 6'h03; addr1_b = 6'h2C;
    #12;
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
    chk("rst_valid0", {31'd0, valid0}, 32'd0);
    chk("rst_valid1", {31'd0, valid1}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_gnt0_b", {31'd0, gnt0_b}, 32'd0);
    req0 = 1'b0; req1 = 1'b0; req0_b = 1'b0; req1_b = 1'b0;
    rst_n = 1'b1;
    last = 32'd0;
    @(posedge clk);
    #1;

    // Single request from requester 0, then idle (rdata holds)
    addr0 = 6'h02;
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, -1);

    // Contention with BURST_MAX = 4
    addr0 = 6'h05; addr1 = 6'h0A;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, seq_c[i]);
    step(1'b0, 1'b0, -1);

    // Owner switch on a single request
    addr0 = 6'h11; addr1 = 6'h22;
    for (int i = 0; i < 7; i++) step(r0_s[i][0], r1_s[i][0], seq_s[i]);
    step(1'b0, 1'b0, -1);

    // Uncontended run longer than BURST_MAX saturates the count; the first
    // contention then goes straight to the waiting side.
    addr0 = 6'h30; addr1 = 6'h3F;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0);
`ifdef IMEM_ARB_FIXED_PRI_EN
    step(1'b1, 1'b1, 0);
    // Fixed priority: requester 0 always wins, 8 cycles
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 0);
    // Dropping req0 grants requester 1 in the same cycle
    step(1'b0, 1'b1, 1);
`else
    step(1'b1, 1'b1, 1);
`endif
    step(1'b0, 1'b0, -1);

    // Reset mid-stream: valid drops without a clock edge
    addr0 = 6'h07;
    step(1'b1, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid0", {31'd0, valid0}, 32'd0);
    chk("midrst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    last = 32'd0;
    #1;
    rst_n = 1'b1;
    // First contention after reset goes to requester 0
    step(1'b1, 1'b1, 0);
    step(1'b0, 1'b0, -1);

    // DUT B, BURST_MAX = 1: both requesting continuously
    req0_b = 1'b1; req1_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
`ifdef IMEM_ARB_FIXED_PRI_EN
      eg_b = 0;
`else
      eg_b = i % 2;
`endif
      #1;
      chk("b_gnt0", {31'd0, gnt0_b}, {31'd0, eg_b == 0});
      chk("b_gnt1", {31'd0, gnt1_b}, {31'd0, eg_b == 1});
      @(posedge clk);
      #1;
      chk("b_valid1", {31'd0, valid1_b}, {31'd0, eg_b == 1});
      chk("b_rdata", rdata_b, mem((eg_b == 1) ? addr1_b : addr0_b));
    end
    req0_b = 1'b0; req1_b = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
